// File: rtl/hmac_arb_pkg.sv
// Shared types and constants for the HMAC job arbiter.
// Used by hmac_arb_pick and hmac_job_arbiter.
package hmac_arb_pkg;

    localparam int unsigned HMAC_ARB_WORD_W  = 32;
    localparam int unsigned HMAC_ARB_HMAC_W  = 512;
    localparam int unsigned HMAC_ARB_MAX_REQ = 4;
    localparam int unsigned HMAC_ARB_IDX_W   = $clog2(HMAC_ARB_MAX_REQ);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

endpackage

// File: rtl/hmac_arb_pick.sv
// Combinational winner picker: round-robin from ptr+1 by default,
// or lowest-index-wins when HMAC_ARB_FIXED_PRIO_EN is defined.
import hmac_arb_pkg::*;

module hmac_arb_pick #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [HMAC_ARB_IDX_W-1:0] ptr,
    output logic [NUM_REQ-1:0]        win,
    output logic [HMAC_ARB_IDX_W-1:0] win_idx
);

    logic found;

`ifdef HMAC_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                win[i]  = 1'b1;
                win_idx = HMAC_ARB_IDX_W'(i);
                found   = 1'b1;
            end
        end
    end
`else
    // Walk offsets 1..NUM_REQ from the pointer; the inner loop keeps every select constant.
    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (((32'(ptr) + off) % NUM_REQ) == i)) begin
                    win[i]  = 1'b1;
                    win_idx = HMAC_ARB_IDX_W'(i);
                    found   = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/hmac_job_arbiter.sv
// Shares one HMAC engine among NUM_REQ (2..4) message-stream requesters, one job at a time.
// Define HMAC_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
import hmac_arb_pkg::*;

module hmac_job_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req,
    output logic [NUM_REQ-1:0]                   grant,
    input  logic [NUM_REQ*HMAC_ARB_WORD_W-1:0]   req_word,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_last,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   resp_valid,
    output logic [HMAC_ARB_HMAC_W-1:0]           resp_hmac,
    output logic                                 busy,
    output logic                                 eng_start_hmac,
    output logic [HMAC_ARB_WORD_W-1:0]           eng_msg_word,
    output logic                                 eng_msg_valid,
    output logic                                 eng_msg_last,
    input  logic                                 eng_msg_ready,
    input  logic [HMAC_ARB_HMAC_W-1:0]           eng_hmac_value,
    input  logic                                 eng_done
);

    arb_state_t                state, state_nxt;
    logic [NUM_REQ-1:0]        pick_win;
    logic [HMAC_ARB_IDX_W-1:0] pick_idx;
    logic [HMAC_ARB_IDX_W-1:0] ptr;

    hmac_arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx)
    );

`ifdef HMAC_ARB_FIXED_PRIO_EN
    logic unused_pick_idx;
    assign unused_pick_idx = ^pick_idx;
    assign ptr = '0;
`else
    logic [HMAC_ARB_IDX_W-1:0] owner_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= HMAC_ARB_IDX_W'(NUM_REQ - 1);
            owner_idx <= '0;
        end else begin
            if (state == ST_IDLE && |req)
                owner_idx <= pick_idx;
            if (state == ST_RESP)
                ptr <= owner_idx;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            grant     <= '0;
            resp_hmac <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && |req)
                grant <= pick_win;
            else if (state == ST_RESP)
                grant <= '0;
            if (state == ST_WAIT && eng_done)
                resp_hmac <= eng_hmac_value;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (|req) state_nxt = ST_START;
            ST_START:  state_nxt = ST_STREAM;
            ST_STREAM: if (eng_msg_valid && eng_msg_ready && eng_msg_last) state_nxt = ST_WAIT;
            ST_WAIT:   if (eng_done) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Owner routing uses the one-hot grant directly; only STREAM opens the path.
    always_comb begin
        eng_msg_word  = '0;
        eng_msg_valid = 1'b0;
        eng_msg_last  = 1'b0;
        req_ready     = '0;
        if (state == ST_STREAM) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    eng_msg_word  = req_word[HMAC_ARB_WORD_W*i +: HMAC_ARB_WORD_W];
                    eng_msg_valid = req_valid[i];
                    eng_msg_last  = req_last[i];
                    req_ready[i]  = eng_msg_ready;
                end
            end
        end
    end

    assign resp_valid     = (state == ST_RESP) ? grant : '0;
    assign busy           = (state != ST_IDLE);
    assign eng_start_hmac = (state == ST_START);

endmodule

// File: tb/tb_hmac_job_arbiter.sv
// Directed self-checking bench for hmac_job_arbiter (default round-robin build, NUM_REQ = 2).
module tb_hmac_job_arbiter;

    localparam int unsigned NUM_REQ = 2;

    logic                    clk;
    logic                    reset;
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ*32-1:0]   req_word;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_last;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      resp_valid;
    logic [511:0]            resp_hmac;
    logic                    busy;
    logic                    eng_start_hmac;
    logic [31:0]             eng_msg_word;
    logic                    eng_msg_valid;
    logic                    eng_msg_last;
    logic                    eng_msg_ready;
    logic [511:0]            eng_hmac_value;
    logic                    eng_done;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned starts = 0;
    int unsigned resp_cnt = 0;
    logic [31:0] got[$];
    logic [31:0] words[3];

    hmac_job_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .grant          (grant),
        .req_word       (req_word),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_hmac      (resp_hmac),
        .busy           (busy),
        .eng_start_hmac (eng_start_hmac),
        .eng_msg_word   (eng_msg_word),
        .eng_msg_valid  (eng_msg_valid),
        .eng_msg_last   (eng_msg_last),
        .eng_msg_ready  (eng_msg_ready),
        .eng_hmac_value (eng_hmac_value),
        .eng_done       (eng_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine-side observer: start pulses, accepted words, completion pulses.
    always @(posedge clk) begin
        if (!reset) begin
            if (eng_start_hmac) starts <= starts + 1;
            if (eng_msg_valid && eng_msg_ready) got.push_back(eng_msg_word);
            if (resp_valid != '0) resp_cnt <= resp_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller has req set at a negedge while IDLE; returns at a negedge in IDLE after completion.
    task automatic do_job(input int unsigned owner, input logic [511:0] hv);
        logic [NUM_REQ-1:0] oh;
        int unsigned base;
        int unsigned starts0;
        oh = '0;
        oh[owner] = 1'b1;
        base = got.size();
        starts0 = starts;
        @(negedge clk);
        chk("job_grant", grant, oh);
        chk("job_start", eng_start_hmac, 1);
        chk("job_busy", busy, 1);
        chk("job_ready_start", req_ready, 0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            req_valid = '0;
            req_last  = '0;
            req_valid[owner] = 1'b1;
            req_last[owner]  = (k == 2);
            req_word[32*owner +: 32] = words[k];
            eng_msg_ready = 1'b1;
            #1;
            chk("job_word", eng_msg_word, words[k]);
            chk("job_req_ready", req_ready, oh);
            @(negedge clk);
        end
        req_valid = '0;
        req_last  = '0;
        chk("job_word_count", got.size() - base, 3);
        for (int k = 0; k < 3; k++)
            if (got.size() > base + k) chk("job_word_order", got[base+k], words[k]);
        eng_hmac_value = hv;
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        eng_hmac_value = '0;
        chk("job_resp_valid", resp_valid, oh);
        chk("job_resp_hmac", resp_hmac, hv);
        @(negedge clk);
        chk("job_idle_grant", grant, 0);
        chk("job_idle_busy", busy, 0);
        chk("job_idle_resp_valid", resp_valid, 0);
        chk("job_start_count", starts - starts0, 1);
    endtask

    initial begin
        logic [31:0] bw[3];
        logic        pat[8];
        int unsigned idx;
        logic [511:0] hv2;

        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        reset = 1'b1;
        req = '0;
        req_word = '0;
        req_valid = '0;
        req_last = '0;
        eng_msg_ready = 1'b0;
        eng_hmac_value = '0;
        eng_done = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_hmac", resp_hmac, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_eng_start", eng_start_hmac, 0);
        chk("rst_eng_valid", {eng_msg_valid, eng_msg_last, eng_msg_word}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single job on requester 0
        req = 2'b01;
        do_job(0, {64{8'hA5}});
        req = '0;
        chk("single_resp_count", resp_cnt, 1);

        // Contention from reset: round-robin 0,1,0,1
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req = 2'b11;
        do_job(0, {16{32'h00000001}});
        do_job(1, {16{32'h00000002}});
        do_job(0, {16{32'h00000003}});
        do_job(1, {16{32'h00000004}});
        req = '0;

        // Backpressure with non-owner noise; last handshake coincides with a stray done
        bw[0] = 32'hAAAA0001;
        bw[1] = 32'hAAAA0002;
        bw[2] = 32'hAAAA0003;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        hv2 = {16{32'h0BADF00D}};
        req = 2'b01;
        @(negedge clk);
        chk("bp_grant", grant, 2'b01);
        @(negedge clk);
        got.delete();
        idx = 0;
        for (int cyc = 0; cyc < 8 && idx < 3; cyc++) begin
            req_valid = 2'b11;
            req_last  = {1'b1, (idx == 2)};
            req_word  = {32'hDEADBEEF, bw[idx]};
            eng_msg_ready = pat[cyc];
            eng_hmac_value = {16{32'hFFFFFFFF}};
            eng_done = (idx == 2) && pat[cyc];
            #1;
            chk("bp_word", eng_msg_word, bw[idx]);
            chk("bp_req_ready", req_ready, {1'b0, pat[cyc]});
            @(negedge clk);
            if (pat[cyc]) idx++;
        end
        req_valid = '0;
        req_last  = '0;
        eng_done  = 1'b0;
        eng_msg_ready = 1'b0;
        chk("bp_all_sent", idx, 3);
        chk("bp_word_count", got.size(), 3);
        if (got.size() == 3) chk("bp_words", {got[0], got[1], got[2]}, {bw[0], bw[1], bw[2]});
        chk("coinc_still_waiting", busy, 1);
        chk("coinc_no_resp", resp_valid, 0);
        @(negedge clk);
        chk("coinc_wait_hmac", resp_hmac, {16{32'h00000004}});
        eng_hmac_value = hv2;
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        eng_hmac_value = '0;
        chk("late_done_resp", resp_valid, 2'b01);
        chk("late_done_hmac", resp_hmac, hv2);
        req = '0;
        @(negedge clk);
        chk("bp_idle", busy, 0);

        // Stray done while idle
        eng_done = 1'b1;
        eng_hmac_value = {16{32'h12345678}};
        @(negedge clk);
        eng_done = 1'b0;
        chk("stray_resp_valid", resp_valid, 0);
        chk("stray_busy", busy, 0);
        @(negedge clk);
        chk("stray_hmac_kept", resp_hmac, hv2);
        eng_hmac_value = '0;

        // Reset mid-stream, then requester 1 alone
        req = 2'b01;
        repeat (2) @(negedge clk);
        req_valid = 2'b01;
        req_word  = {32'h0, 32'h55555555};
        eng_msg_ready = 1'b1;
        #1;
        chk("mid_streaming", eng_msg_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hmac", resp_hmac, 0);
        chk("mid_rst_stream", {eng_msg_valid, eng_msg_last, eng_msg_word, req_ready}, 0);
        @(negedge clk);
        reset = 1'b0;
        req_valid = '0;
        req = 2'b10;
        do_job(1, {64{8'h3C}});
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
